change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/vm_pkg.sv | 47 ++++
 rtl/coin_pulse_timer.sv | 25 ++
 rtl/change_dispenser.sv | 121 ++++++++++++
 3 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the change dispenser: coin values, coin_out bit positions,
// amount limit and FSM state encoding.
package vm_pkg;

    localparam logic [6:0] MAX_AMOUNT = 7'd99;

    // Coin values in units of 100
    localparam logic [6:0] COIN_VAL_100  = 7'd1;
    localparam logic [6:0] COIN_VAL_500  = 7'd5;
    localparam logic [6:0] COIN_VAL_1000 = 7'd10;
    localparam logic [6:0] COIN_VAL_5000 = 7'd50;

    localparam int COIN_BIT_100  = 0;
    localparam int COIN_BIT_500  = 1;
    localparam int COIN_BIT_1000 = 2;
    localparam int COIN_BIT_5000 = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Greedy choice: one-hot mask of the largest coin not exceeding rem (0 if rem is 0)
    function automatic logic [3:0] pick_coin(input logic [6:0] rem);
        logic [3:0] coin;
        coin = '0;
        if (rem >= COIN_VAL_5000)      coin[COIN_BIT_5000] = 1'b1;
        else if (rem >= COIN_VAL_1000) coin[COIN_BIT_1000] = 1'b1;
        else if (rem >= COIN_VAL_500)  coin[COIN_BIT_500]  = 1'b1;
        else if (rem >= COIN_VAL_100)  coin[COIN_BIT_100]  = 1'b1;
        return coin;
    endfunction

    function automatic logic [6:0] coin_value(input logic [3:0] coin);
        logic [6:0] val;
        val = '0;
        if (coin[COIN_BIT_5000])      val = COIN_VAL_5000;
        else if (coin[COIN_BIT_1000]) val = COIN_VAL_1000;
        else if (coin[COIN_BIT_500])  val = COIN_VAL_500;
        else if (coin[COIN_BIT_100])  val = COIN_VAL_100;
        return val;
    endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// Down-counter timing the PULSE and GAP phases; expired is high once length cycles
// have elapsed since load (including the cycle after the loading edge).
module coin_pulse_timer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [3:0] length,
    output logic       expired
);

    logic [3:0] count_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= length - 4'd1;
        end else if (count_reg != 4'd0) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign expired = (count_reg == 4'd0);

endmodule

// File: rtl/change_dispenser.sv
// Greedy coin dispenser: pays out amount (units of 100) as timed one-hot coin pulses,
// largest coin first, with abort and rejection of out-of-range requests.
module change_dispenser
    import vm_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [6:0] amount,
    input  logic       abort,
    output logic [3:0] coin_out,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [6:0] remaining
);

    localparam logic [3:0] PULSE_LEN = 4'(PULSE_CYCLES);
    localparam logic [3:0] GAP_LEN   = 4'(GAP_CYCLES);

    state_t     state_reg, state_next;
    logic [6:0] remaining_reg, remaining_next;
    logic [3:0] coin_reg, coin_next;
    logic       error_reg, error_next;
    logic       timer_load;
    logic [3:0] timer_length;
    logic       timer_expired;
    logic [3:0] sel_coin;

    assign sel_coin = pick_coin(remaining_reg);

    coin_pulse_timer u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (timer_load),
        .length  (timer_length),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            remaining_reg <= '0;
            coin_reg      <= '0;
            error_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            coin_reg      <= coin_next;
            error_reg     <= error_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        coin_next      = coin_reg;
        error_next     = 1'b0;
        timer_load     = 1'b0;
        timer_length   = PULSE_LEN;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (amount <= MAX_AMOUNT) begin
                        remaining_next = amount;
                        state_next     = ST_SELECT;
                    end else begin
                        error_next = 1'b1;
                    end
                end
            end
            ST_SELECT: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (remaining_reg == 7'd0) begin
                    state_next = ST_DONE;
                end else begin
                    coin_next      = sel_coin;
                    remaining_next = remaining_reg - coin_value(sel_coin);
                    timer_load     = 1'b1;
                    timer_length   = PULSE_LEN;
                    state_next     = ST_PULSE;
                end
            end
            ST_PULSE: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (timer_expired) begin
                    timer_load   = 1'b1;
                    timer_length = GAP_LEN;
                    state_next   = ST_GAP;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (timer_expired) begin
                    state_next = ST_SELECT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // coin_reg persists between coins; gating on PULSE keeps coin_out clean elsewhere
    assign coin_out  = (state_reg == ST_PULSE) ? coin_reg : 4'd0;
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign error     = error_reg;
    assign remaining = remaining_reg;

endmodule
